// File: rtl/mult_add_seq.sv
// Sequential shift-and-add multiply-accumulate: p = q*b + r, one multiplier bit per clock.
// Rebuilds a dividend from quotient/divisor/remainder; with r = 0 it is a plain unsigned multiplier.
module mult_add_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   q,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   r,
  output logic [2*WIDTH-1:0] p,
  output logic               ovf,
  output logic               rem_err,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;
  logic            ovf_q, ovf_d;
  logic            rem_err_q, rem_err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   acc_sum;

  // Conditional add of the shifted multiplicand for the current multiplier bit; cannot carry out.
  assign acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    p_d       = p_q;
    ovf_d     = ovf_q;
    rem_err_d = rem_err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d   = {{WIDTH{1'b0}}, b};
          mplier_d  = q;
          acc_d     = {{WIDTH{1'b0}}, r};
          count_d   = CW'(WIDTH);
          rem_err_d = (r >= b);
          busy_d    = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          p_d     = acc_sum;
          ovf_d   = |acc_sum[PW-1:WIDTH];
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, including a result in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      p_q       <= '0;
      ovf_q     <= 1'b0;
      rem_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      p_q       <= p_d;
      ovf_q     <= ovf_d;
      rem_err_q <= rem_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign p       = p_q;
  assign ovf     = ovf_q;
  assign rem_err = rem_err_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_mult_add_seq.sv
// Self-checking bench for mult_add_seq against an arithmetic reference (q*b + r).
module tb_mult_add_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] q, b, r;
  logic [31:0] p;
  logic        ovf, rem_err, busy, done;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] last_p;

  mult_add_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .q(q), .b(b), .r(r),
    .p(p), .ovf(ovf), .rem_err(rem_err), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One operation: start pulse, optional ignored start pokes while busy, checks latency and result.
  task automatic run_op(input logic [15:0] qi, input logic [15:0] bi, input logic [15:0] ri,
                        input bit poke);
    logic [31:0] exp_p;
    int lat, busy_n, extra;
    bit seen;
    exp_p = 32'(qi) * 32'(bi) + 32'(ri);
    @(negedge clk);
    q = qi; b = bi; r = ri; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    q = 16'($urandom); b = 16'($urandom); r = 16'($urandom);
    check("p_held", 64'(p), 64'(last_p));
    lat = 0; busy_n = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      if (busy) busy_n++;
      if (done) seen = 1'b1;
      else begin
        if (poke && lat == 7) begin
          start = 1'b1; q = 16'd100; b = 16'd100; r = 16'd0;
        end
        @(posedge clk); #1;
        start = 1'b0;
        lat++;
      end
    end
    check("latency", 64'(lat), 64'd16);
    check("busy_cycles", 64'(busy_n), 64'd17);
    check("p", 64'(p), 64'(exp_p));
    check("ovf", 64'(ovf), 64'(exp_p[31:16] != 16'd0));
    check("rem_err", 64'(rem_err), 64'(ri >= bi));
    if (poke) begin
      start = 1'b1; q = 16'd100; b = 16'd100; r = 16'd0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("done_single", 64'(done), 64'd0);
    check("busy_clear", 64'(busy), 64'd0);
    last_p = exp_p;
    if (poke) begin
      extra = 0;
      repeat (25) begin
        @(posedge clk); #1;
        if (done || busy) extra++;
      end
      check("no_second_op", 64'(extra), 64'd0);
      check("p_kept", 64'(p), 64'(exp_p));
    end
  endtask

  initial begin : main
    int t_prev, cyc, pulses, extra;
    logic [15:0] a, dv, y, rm;

    rst = 1'b0; start = 1'b0; q = '0; b = '0; r = '0;
    last_p = '0;
    #1;
    check("rst_p", 64'(p), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_rem_err", 64'(rem_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Directed cases.
    run_op(16'd7, 16'd9, 16'd2, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    run_op(16'h1234, 16'h0000, 16'h0005, 1'b0);
    run_op(16'h0000, 16'h1234, 16'h0042, 1'b0);
    run_op(16'd3, 16'd5, 16'd1, 1'b1);

    // Reset during RUN: immediate clear, no done pulse.
    @(negedge clk);
    q = 16'h00FF; b = 16'h0100; r = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_p", 64'(p), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check("midrst_quiet", 64'(extra), 64'd0);
    last_p = '0;
    run_op(16'h00FF, 16'h0100, 16'h0001, 1'b0);

    // start held high: one op per IDLE visit, 18 cycles apart.
    @(negedge clk);
    q = 16'd2; b = 16'd3; r = 16'd1; start = 1'b1;
    cyc = 0; pulses = 0; t_prev = 0;
    while (pulses < 3 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        check("hold_p", 64'(p), 64'd7);
        if (pulses == 0) check("hold_first", 64'(cyc), 64'd17);
        else check("hold_period", 64'(cyc - t_prev), 64'd18);
        t_prev = cyc;
        pulses++;
      end
    end
    check("hold_pulses", 64'(pulses), 64'd3);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hold_idle", 64'(busy), 64'd0);
    last_p = 32'd7;

    // Divider round trip: (a / d, a % d) must rebuild a exactly.
    for (int i = 0; i < 1000; i++) begin
      a  = 16'($urandom);
      dv = 16'($urandom_range(1, 65535));
      if (i % 4 == 0) dv = 16'($urandom_range(1, 15));
      y  = a / dv;
      rm = a % dv;
      run_op(y, dv, rm, 1'b0);
    end

    // Unconstrained operands against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      run_op(16'($urandom), 16'($urandom), 16'($urandom), (i % 10) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
